// File: rtl/vga_pkg.sv
// vga_pkg: VGA raster timing sets (640x480@60 default, 800x600@60 alternate)
// plus helpers shared by the axis counter and the timing generator top.
package vga_pkg;

    localparam int unsigned VGA_CW = 12;

    // 640x480@60, 25.175 MHz pixel clock, both syncs active-low
    localparam int unsigned VGA640_H_ACTIVE     = 640;
    localparam int unsigned VGA640_H_SYNC_START = 656;
    localparam int unsigned VGA640_H_SYNC_END   = 752;
    localparam int unsigned VGA640_H_TOTAL      = 800;
    localparam int unsigned VGA640_V_ACTIVE     = 480;
    localparam int unsigned VGA640_V_SYNC_START = 490;
    localparam int unsigned VGA640_V_SYNC_END   = 492;
    localparam int unsigned VGA640_V_TOTAL      = 525;
    localparam bit          VGA640_H_SYNC_POL   = 1'b0;
    localparam bit          VGA640_V_SYNC_POL   = 1'b0;

    // 800x600@60, 40 MHz pixel clock, both syncs active-high
    localparam int unsigned VGA800_H_ACTIVE     = 800;
    localparam int unsigned VGA800_H_SYNC_START = 840;
    localparam int unsigned VGA800_H_SYNC_END   = 968;
    localparam int unsigned VGA800_H_TOTAL      = 1056;
    localparam int unsigned VGA800_V_ACTIVE     = 600;
    localparam int unsigned VGA800_V_SYNC_START = 601;
    localparam int unsigned VGA800_V_SYNC_END   = 605;
    localparam int unsigned VGA800_V_TOTAL      = 628;
    localparam bit          VGA800_H_SYNC_POL   = 1'b1;
    localparam bit          VGA800_V_SYNC_POL   = 1'b1;

    typedef struct packed {
        logic last;
        logic sync;
        logic active;
        logic first;
    } axis_flags_t;

    function automatic bit axis_legal(
        input int unsigned active,
        input int unsigned sync_start,
        input int unsigned sync_end,
        input int unsigned total,
        input int unsigned cw
    );
        return (active < sync_start) && (sync_start < sync_end) &&
               (sync_end <= total) &&
               (longint'(total) <= (longint'(1) << cw));
    endfunction

    function automatic logic sync_level(
        input logic asserted,
        input logic pol
    );
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (H or V) - wrapping count plus
// last/sync/active/first compares decoded from the current count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned CW         = VGA_CW,
    parameter int unsigned ACTIVE     = VGA640_H_ACTIVE,
    parameter int unsigned SYNC_START = VGA640_H_SYNC_START,
    parameter int unsigned SYNC_END   = VGA640_H_SYNC_END,
    parameter int unsigned TOTAL      = VGA640_H_TOTAL
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output axis_flags_t   flags_o
);

    if (!axis_legal(ACTIVE, SYNC_START, SYNC_END, TOTAL, CW)) begin : g_bad_timing
        $error("vga_axis_counter: illegal timing parameters");
    end

    // Compares run one bit wider so SYNC_END == TOTAL == 2**CW still fits.
    localparam logic [CW:0] LAST_W  = (CW+1)'(TOTAL - 1);
    localparam logic [CW:0] ACT_W   = (CW+1)'(ACTIVE);
    localparam logic [CW:0] SS_W    = (CW+1)'(SYNC_START);
    localparam logic [CW:0] SE_W    = (CW+1)'(SYNC_END);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW:0]   cnt_w;

    assign cnt_w = {1'b0, cnt_q};

    always_comb begin
        flags_o        = '0;
        flags_o.last   = (cnt_w == LAST_W);
        flags_o.sync   = (cnt_w >= SS_W) && (cnt_w < SE_W);
        flags_o.active = (cnt_w < ACT_W);
        flags_o.first  = (cnt_q == '0);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = flags_o.last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator, one pixel clock domain.
// Define VGA_TIMING_CE_EN to add the i_ce pixel enable (e.g. pixels from CLOCK_50).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CW           = VGA_CW,
    parameter int unsigned H_ACTIVE     = VGA640_H_ACTIVE,
    parameter int unsigned H_SYNC_START = VGA640_H_SYNC_START,
    parameter int unsigned H_SYNC_END   = VGA640_H_SYNC_END,
    parameter int unsigned H_TOTAL      = VGA640_H_TOTAL,
    parameter int unsigned V_ACTIVE     = VGA640_V_ACTIVE,
    parameter int unsigned V_SYNC_START = VGA640_V_SYNC_START,
    parameter int unsigned V_SYNC_END   = VGA640_V_SYNC_END,
    parameter int unsigned V_TOTAL      = VGA640_V_TOTAL,
    parameter bit          H_SYNC_POL   = VGA640_H_SYNC_POL,
    parameter bit          V_SYNC_POL   = VGA640_V_SYNC_POL
) (
    input  logic          i_clk,
    input  logic          i_rst,
`ifdef VGA_TIMING_CE_EN
    input  logic          i_ce,
`endif
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic          o_vblank_start
);

    localparam logic          HS_IDLE      = sync_level(1'b0, H_SYNC_POL);
    localparam logic          VS_IDLE      = sync_level(1'b0, V_SYNC_POL);
    localparam logic [CW-1:0] V_BLANK_LINE = CW'(V_ACTIVE);

    logic ce;
`ifdef VGA_TIMING_CE_EN
    assign ce = i_ce;
`else
    assign ce = 1'b1;
`endif

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    axis_flags_t   h_f;
    axis_flags_t   v_f;
    logic          unused_v_last;

    vga_axis_counter #(
        .CW         (CW),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SYNC_START),
        .SYNC_END   (H_SYNC_END),
        .TOTAL      (H_TOTAL)
    ) u_h (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .en_i    (ce),
        .cnt_o   (h_cnt),
        .flags_o (h_f)
    );

    // V steps in the same clock as the H wrap, so lines abut with no gap cycle.
    vga_axis_counter #(
        .CW         (CW),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SYNC_START),
        .SYNC_END   (V_SYNC_END),
        .TOTAL      (V_TOTAL)
    ) u_v (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .en_i    (ce & h_f.last),
        .cnt_o   (v_cnt),
        .flags_o (v_f)
    );

    assign unused_v_last = v_f.last;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_q, line_d;
    logic          frame_q, frame_d;
    logic          vblank_q, vblank_d;

    // Levels hold while disabled; pulses drop so each fires once per pixel.
    always_comb begin
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        de_d     = de_q;
        x_d      = x_q;
        y_d      = y_q;
        line_d   = 1'b0;
        frame_d  = 1'b0;
        vblank_d = 1'b0;
        if (ce) begin
            hsync_d  = sync_level(h_f.sync, H_SYNC_POL);
            vsync_d  = sync_level(v_f.sync, V_SYNC_POL);
            de_d     = h_f.active & v_f.active;
            x_d      = h_cnt;
            y_d      = v_cnt;
            line_d   = h_f.first;
            frame_d  = h_f.first & v_f.first;
            vblank_d = h_f.first & (v_cnt == V_BLANK_LINE);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hsync_q  <= HS_IDLE;
            vsync_q  <= VS_IDLE;
            de_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            de_q     <= de_d;
            x_q      <= x_d;
            y_q      <= y_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
            vblank_q <= vblank_d;
        end
    end

    assign o_hsync        = hsync_q;
    assign o_vsync        = vsync_q;
    assign o_de           = de_q;
    assign o_x            = x_q;
    assign o_y            = y_q;
    assign o_line_start   = line_q;
    assign o_frame_start  = frame_q;
    assign o_vblank_start = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default 640x480 instance plus a tiny-raster instance,
// both checked every cycle against a pixel-index reference model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int HA = 640, HSS = 656, HSE = 752, HT = 800;
    localparam int VA = 480, VSS = 490, VSE = 492, VT = 525;
    localparam int SHA = 8, SHSS = 10, SHSE = 12, SHT = 14;
    localparam int SVA = 4, SVSS = 5, SVSE = 6, SVT = 7;
`ifdef VGA_TIMING_CE_EN
    localparam bit CE_EN = 1'b1;
`else
    localparam bit CE_EN = 1'b0;
`endif

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        ls;
        logic        fs;
        logic        vb;
    } vo_t;

    localparam vo_t RST_D = '{hs: 1'b1, vs: 1'b1, default: '0};
    localparam vo_t RST_S = '{hs: 1'b0, vs: 1'b1, default: '0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1;
    logic rst_s = 1'b1;
    logic ce    = 1'b1;

    logic        d_hs, d_vs, d_de, d_ls, d_fs, d_vb;
    logic [11:0] d_x, d_y;
    logic        s_hs, s_vs, s_de, s_ls, s_fs, s_vb;
    logic [11:0] s_x, s_y;

    int checks = 0;
    int passes = 0;

    vga_timing_gen dut (
        .i_clk          (clk),
        .i_rst          (rst_d),
`ifdef VGA_TIMING_CE_EN
        .i_ce           (ce),
`endif
        .o_hsync        (d_hs),
        .o_vsync        (d_vs),
        .o_de           (d_de),
        .o_x            (d_x),
        .o_y            (d_y),
        .o_line_start   (d_ls),
        .o_frame_start  (d_fs),
        .o_vblank_start (d_vb)
    );

    vga_timing_gen #(
        .H_ACTIVE(SHA), .H_SYNC_START(SHSS), .H_SYNC_END(SHSE), .H_TOTAL(SHT),
        .V_ACTIVE(SVA), .V_SYNC_START(SVSS), .V_SYNC_END(SVSE), .V_TOTAL(SVT),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
    ) dut_s (
        .i_clk          (clk),
        .i_rst          (rst_s),
`ifdef VGA_TIMING_CE_EN
        .i_ce           (ce),
`endif
        .o_hsync        (s_hs),
        .o_vsync        (s_vs),
        .o_de           (s_de),
        .o_x            (s_x),
        .o_y            (s_y),
        .o_line_start   (s_ls),
        .o_frame_start  (s_fs),
        .o_vblank_start (s_vb)
    );

    vo_t act_d, act_s, exp_d, exp_s;
    assign act_d = {d_hs, d_vs, d_de, d_x, d_y, d_ls, d_fs, d_vb};
    assign act_s = {s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs, s_vb};

    // Reference: n = enabled pixels since reset release (-1 = reset state)
    int nd = -1, ns = -1;
    bit pd = 1'b0, ps = 1'b0;

    function automatic vo_t model(input int n, input bit p,
                                  input int ha, input int hss, input int hse, input int ht,
                                  input int va, input int vss, input int vse, input int vt,
                                  input bit hp, input bit vp);
        vo_t e;
        int h, v;
        e = '0;
        e.hs = ~hp;
        e.vs = ~vp;
        if (n >= 0) begin
            h = n % ht;
            v = (n / ht) % vt;
            e.hs = (h >= hss && h < hse) ? hp : ~hp;
            e.vs = (v >= vss && v < vse) ? vp : ~vp;
            e.de = (h < ha) && (v < va);
            e.x  = 12'(h);
            e.y  = 12'(v);
            e.ls = p && (h == 0);
            e.fs = p && (h == 0) && (v == 0);
            e.vb = p && (h == 0) && (v == va);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        bit en;
        en = CE_EN ? ce : 1'b1;
        if (rst_d) begin nd = -1; pd = 1'b0; end
        else if (en) begin nd = nd + 1; pd = 1'b1; end
        else pd = 1'b0;
        if (rst_s) begin ns = -1; ps = 1'b0; end
        else if (en) begin ns = ns + 1; ps = 1'b1; end
        else ps = 1'b0;
    end

    assign exp_d = model(nd, pd, HA, HSS, HSE, HT, VA, VSS, VSE, VT, 1'b0, 1'b0);
    assign exp_s = model(ns, ps, SHA, SHSS, SHSE, SHT, SVA, SVSS, SVSE, SVT, 1'b1, 1'b0);

    task automatic test_reset();
        rst_d = 1'b1; rst_s = 1'b1; ce = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (act_d !== RST_D) $display("FAIL reset_d act=%h exp=%h", act_d, RST_D);
            else passes++;
            checks++;
            if (act_s !== RST_S) $display("FAIL reset_s act=%h exp=%h", act_s, RST_S);
            else passes++;
        end
        rst_d = 1'b0; rst_s = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({d_x, d_y, d_de, d_fs, d_ls, d_hs, d_vs} !== {12'd0, 12'd0, 5'b11111})
            $display("FAIL first_pixel_d act=%h exp=%h", act_d, exp_d);
        else passes++;
        checks++;
        if (act_s !== exp_s) $display("FAIL first_pixel_s act=%h exp=%h", act_s, exp_s);
        else passes++;
    endtask

    task automatic test_line();
        int hs_low = 0, hs_xmin = 9999, hs_xmax = -1;
        int de_n = 0, de_xmax = -1;
        int ls_t[$];
        ce = 1'b1;
        rst_d = 1'b1;
        @(posedge clk); #1;
        rst_d = 1'b0;
        for (int i = 0; i < 2 * HT; i++) begin
            @(posedge clk); #1;
            checks++;
            if (act_d !== exp_d) $display("FAIL line_model i=%0d act=%h exp=%h", i, act_d, exp_d);
            else passes++;
            if (i < HT) begin
                if (!d_hs) begin
                    hs_low++;
                    if (int'(d_x) < hs_xmin) hs_xmin = int'(d_x);
                    if (int'(d_x) > hs_xmax) hs_xmax = int'(d_x);
                end
                if (d_de) begin
                    de_n++;
                    if (int'(d_x) > de_xmax) de_xmax = int'(d_x);
                end
            end
            if (d_ls) ls_t.push_back(i);
        end
        checks++;
        if (hs_low != HSE - HSS) $display("FAIL hsync_width act=%0d exp=%0d", hs_low, HSE - HSS);
        else passes++;
        checks++;
        if (hs_xmin != HSS || hs_xmax != HSE - 1)
            $display("FAIL hsync_range act=%0d..%0d exp=%0d..%0d", hs_xmin, hs_xmax, HSS, HSE - 1);
        else passes++;
        checks++;
        if (de_n != HA || de_xmax != HA - 1)
            $display("FAIL de_span act=%0d/%0d exp=%0d/%0d", de_n, de_xmax, HA, HA - 1);
        else passes++;
        checks++;
        if (ls_t.size() != 2 || ls_t[1] - ls_t[0] != HT)
            $display("FAIL line_period act_n=%0d exp_period=%0d", ls_t.size(), HT);
        else passes++;
    endtask

    task automatic test_frames();
        int fs_t[$];
        int vs_low = 0, vs_bad_y = 0, vb_n = 0, vb_bad = 0, hs_bad = 0;
        int px = -1, py = -1;
        int frame = SHT * SVT;
        ce = 1'b1;
        rst_s = 1'b1;
        @(posedge clk); #1;
        rst_s = 1'b0;
        for (int i = 0; i < 2 * frame + 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (act_s !== exp_s) $display("FAIL frame_model i=%0d act=%h exp=%h", i, act_s, exp_s);
            else passes++;
            if (s_fs) fs_t.push_back(i);
            if (i < frame && !s_vs) begin
                vs_low++;
                if (s_y != 12'(SVSS)) vs_bad_y++;
            end
            if (i < 2 * frame && s_vb) begin
                vb_n++;
                if (s_x != 0 || s_y != 12'(SVA)) vb_bad++;
            end
            if (s_hs !== (s_x >= 12'(SHSS) && s_x < 12'(SHSE))) hs_bad++;
            if (px == SHT - 1) begin
                checks++;
                if (s_x != 0 || int'(s_y) != (py + 1) % SVT)
                    $display("FAIL wrap act=(%0d,%0d) exp=(0,%0d)", s_x, s_y, (py + 1) % SVT);
                else passes++;
            end
            px = int'(s_x);
            py = int'(s_y);
        end
        checks++;
        if (fs_t.size() != 3 || fs_t[1] - fs_t[0] != frame)
            $display("FAIL frame_period act_n=%0d exp_period=%0d", fs_t.size(), frame);
        else passes++;
        checks++;
        if (vs_low != (SVSE - SVSS) * SHT || vs_bad_y != 0)
            $display("FAIL vsync_width act=%0d bad_y=%0d exp=%0d", vs_low, vs_bad_y,
                     (SVSE - SVSS) * SHT);
        else passes++;
        checks++;
        if (vb_n != 2 || vb_bad != 0) $display("FAIL vblank_pulse act=%0d bad=%0d exp=2", vb_n, vb_bad);
        else passes++;
        checks++;
        if (hs_bad != 0) $display("FAIL hsync_pol act=%0d exp=0", hs_bad);
        else passes++;
    endtask

    task automatic test_mid_reset();
        ce = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int tx, ty, budget;
            tx = $urandom_range(0, SHT - 1);
            ty = $urandom_range(0, SVT - 1);
            budget = 0;
            while (!(int'(s_x) == tx && int'(s_y) == ty) && budget < 3 * SHT * SVT) begin
                @(posedge clk); #1;
                budget++;
            end
            checks++;
            if (budget >= 3 * SHT * SVT) $display("FAIL reach_target act=(%0d,%0d) exp=(%0d,%0d)",
                                                   s_x, s_y, tx, ty);
            else passes++;
            rst_d = 1'b1; rst_s = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (act_s !== RST_S) $display("FAIL midreset_s act=%h exp=%h", act_s, RST_S);
            else passes++;
            checks++;
            if (act_d !== RST_D) $display("FAIL midreset_d act=%h exp=%h", act_d, RST_D);
            else passes++;
            rst_d = 1'b0; rst_s = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (s_x != 0 || s_y != 0 || !s_fs || !s_ls)
                $display("FAIL restart_s act=%h exp=%h", act_s, exp_s);
            else passes++;
            checks++;
            if (act_d !== exp_d) $display("FAIL restart_d act=%h exp=%h", act_d, exp_d);
            else passes++;
        end
    endtask

    task automatic test_ce();
        int ls_t[$];
        int fs_n = 0, fs_run = 0, fs_max = 0, px = 0;
        int clocks = 4 * SHT * SVT * 8;
        int en_edges, exp_fs;
        bit ce_at;
        rst_d = 1'b1; rst_s = 1'b1; ce = 1'b1;
        @(posedge clk); #1;
        rst_d = 1'b0; rst_s = 1'b0;
        for (int i = 0; i < 2 * HT * 2; i++) begin
            ce_at = (i % 2 == 0);
            ce = ce_at;
            @(posedge clk); #1;
            checks++;
            if (act_d !== exp_d || act_s !== exp_s)
                $display("FAIL ce_model i=%0d act=%h/%h exp=%h/%h", i, act_d, act_s, exp_d, exp_s);
            else passes++;
            if (d_ls) ls_t.push_back(i);
            if (i < clocks) begin
                if (s_fs) begin
                    fs_run++;
                    if (fs_run == 1) fs_n++;
                end else fs_run = 0;
                if (fs_run > fs_max) fs_max = fs_run;
            end
            if (i > 0) begin
                checks++;
                if ((int'(s_x) == px) !== (CE_EN && !ce_at))
                    $display("FAIL ce_hold i=%0d act_x=%0d prev_x=%0d", i, s_x, px);
                else passes++;
            end
            px = int'(s_x);
        end
        ce = 1'b1;
        checks++;
        if (ls_t.size() < 2 || ls_t[1] - ls_t[0] != (CE_EN ? 2 * HT : HT))
            $display("FAIL ce_line_period act_n=%0d exp_period=%0d", ls_t.size(),
                     CE_EN ? 2 * HT : HT);
        else passes++;
        en_edges = CE_EN ? clocks / 2 : clocks;
        exp_fs = (en_edges + SHT * SVT - 1) / (SHT * SVT);
        checks++;
        if (fs_max != 1 || fs_n != exp_fs)
            $display("FAIL ce_frame_pulse act_w=%0d act_n=%0d exp_w=1 exp_n=%0d", fs_max, fs_n, exp_fs);
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            ce    = CE_EN ? ($urandom_range(0, 3) != 0) : 1'b1;
            rst_d = ($urandom_range(0, 299) == 0);
            rst_s = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
            checks++;
            if (act_d !== exp_d) $display("FAIL rand_d i=%0d act=%h exp=%h", i, act_d, exp_d);
            else passes++;
            checks++;
            if (act_s !== exp_s) $display("FAIL rand_s i=%0d act=%h exp=%h", i, act_s, exp_s);
            else passes++;
        end
        rst_d = 1'b0; rst_s = 1'b0; ce = 1'b1;
    endtask

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_mid_reset();
        test_ce();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
